if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS
// pipeline. Drives the program counter, fetches from instruction memory over a
// variable-latency req/ack handshake, and presents instr_ID / PC_ID / valid_ID
// to the decode stage. It stalls on hazard_detected. A taken branch resolved in
// ID redirects the PC and flushes the fetch slot.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   hazard_detected     freezes PC and IF/ID
//   branch_taken        taken branch/jump from ID (qualified by valid_ID, !stall)
//   branch_target       redirect address, valid with branch_taken
//   imem_req/imem_addr  fetch request; stable from raise until the ack cycle
//   imem_ack/imem_rdata memory response; data valid only in the ack cycle
//   PC_ID, instr_ID     PC+PC_STEP and instruction word held in ID
//   valid_ID            0 marks a bubble in ID
//
// Optional feature (macro IF_PERF_CNT_EN): adds saturating counters
//   stall_cycles (cycles with hazard_detected) and flush_count (redirects).
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = {WORD_LEN{1'b0}},
    parameter int                  PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] PC_ID,
    output logic [WORD_LEN-1:0] instr_ID,
    output logic                valid_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_count
`endif
);

    localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(PC_STEP);

    // FETCH: request outstanding. HOLD: a word was accepted during a stall and
    // waits in the skid register. DRAIN: a redirect killed an outstanding
    // request, which must still be acked before the new address is issued.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] pc_id_q, pc_id_d;
    logic [WORD_LEN-1:0] instr_id_q, instr_id_d;
    logic                valid_id_q, valid_id_d;
    logic [WORD_LEN-1:0] skid_q, skid_d;
    logic [WORD_LEN-1:0] redirect_pc_q, redirect_pc_d;
    logic                redir_s;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;
`endif

    // A branch only counts when a real instruction in ID is not being stalled.
    assign redir_s   = branch_taken & valid_id_q & ~hazard_detected;

    // The request is dropped only while a word sits in the skid register; during
    // DRAIN the killed request stays up at the old PC until it is acked.
    assign imem_req  = ~rst & (state_q != ST_HOLD);
    assign imem_addr = pc_q;
    assign PC_ID     = pc_id_q;
    assign instr_ID  = instr_id_q;
    assign valid_ID  = valid_id_q;

    // Next-state and IF/ID update logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_id_d       = pc_id_q;
        instr_id_d    = instr_id_q;
        valid_id_d    = valid_id_q;
        skid_d        = skid_q;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            ST_FETCH: begin
                if (redir_s) begin
                    valid_id_d = 1'b0;
                    if (imem_ack) begin
                        // Wrong-path word returned together with the redirect.
                        pc_d = branch_target;
                    end else begin
                        redirect_pc_d = branch_target;
                        state_d       = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!hazard_detected) begin
                        instr_id_d = imem_rdata;
                        pc_id_d    = pc_q + STEP;
                        valid_id_d = 1'b1;
                        pc_d       = pc_q + STEP;
                    end else begin
                        // Data is only valid this cycle, so park it.
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else begin
                    if (!hazard_detected) begin
                        valid_id_d = 1'b0;
                    end else begin
                        valid_id_d = valid_id_q;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_s) begin
                    valid_id_d = 1'b0;
                    pc_d       = branch_target;
                    state_d    = ST_FETCH;
                end else if (!hazard_detected) begin
                    instr_id_d = skid_q;
                    pc_id_d    = pc_q + STEP;
                    valid_id_d = 1'b1;
                    pc_d       = pc_q + STEP;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                valid_id_d = 1'b0;
                if (imem_ack) begin
                    pc_d    = redirect_pc_q;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                valid_id_d = 1'b0;
                state_d    = ST_FETCH;
            end
        endcase
    end

    // Pipeline and fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            pc_id_q       <= {WORD_LEN{1'b0}};
            instr_id_q    <= {WORD_LEN{1'b0}};
            valid_id_q    <= 1'b0;
            skid_q        <= {WORD_LEN{1'b0}};
            redirect_pc_q <= {WORD_LEN{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_id_q       <= pc_id_d;
            instr_id_q    <= instr_id_d;
            valid_id_q    <= valid_id_d;
            skid_q        <= skid_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating performance counter increments.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (hazard_detected && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (redir_s && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
